// File: rtl/mmio_q_pkg.sv
// Shared definitions for the MMIO write queue: parameter defaults and status-register layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Status image layout: count occupies bits [CW-1:0] (CW = $clog2(DEPTH)+1); the four flags sit
// directly above it at the *_REL offsets below. The *_BIT constants are the absolute
// positions for the default depth.
package mmio_q_pkg;

  localparam int Q_WIDTH_DEF = 64;
  localparam int Q_DEPTH_DEF = 8;

  localparam int Q_STATUS_W = 64;

  // Flag offsets relative to the top of the count field.
  localparam int ST_EMPTY_REL = 0;
  localparam int ST_FULL_REL  = 1;
  localparam int ST_UNDER_REL = 2;
  localparam int ST_OVER_REL  = 3;

  // Absolute bit positions for the default depth.
  localparam int Q_CNT_W_DEF  = $clog2(Q_DEPTH_DEF) + 1;
  localparam int ST_EMPTY_BIT = Q_CNT_W_DEF + ST_EMPTY_REL;
  localparam int ST_FULL_BIT  = Q_CNT_W_DEF + ST_FULL_REL;
  localparam int ST_UNDER_BIT = Q_CNT_W_DEF + ST_UNDER_REL;
  localparam int ST_OVER_BIT  = Q_CNT_W_DEF + ST_OVER_REL;

endpackage

// File: rtl/mmio_wr_queue_mem.sv
// Storage array for the MMIO write queue: one write port, one registered read port.
// Latency: read data appears 1 cycle after re/rzero; write lands on the same edge.
// Backpressure: none; the caller guarantees pointer legality.
// Ports: clk, rst_n; we/waddr/wdata write port; re/raddr read port; rzero loads zero into
// the read register instead of an entry; rdata is the read register (held when idle).
// The array itself is deliberately not reset; only the read register is.
module mmio_wr_queue_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rzero,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to raddr (full queue, push+pop) returns the old entry,
  // which is the oldest one as required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rzero) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mmio_wr_queue.sv
// MMIO write queue: circular FIFO with sticky error flags, status image and optional statistics.
// Latency: rd_data/rd_valid 1 cycle after rd_en; count/full/empty update the cycle after the event.
// Backpressure: none; push on full (no pop) is dropped and sets overflow, pop on empty returns 0 and sets underflow.
// Ports: clk, rst_n (async active-low); wr_en/wr_data push; rd_en pop; flush empties the queue;
// clr_err clears the sticky flags; rd_data/rd_valid popped word; count/full/empty occupancy;
// overflow/underflow sticky errors; status 64-bit register image; push_cnt/pop_cnt statistics.
// Build option: define MMIO_WR_QUEUE_STATS_EN to implement push_cnt/pop_cnt (otherwise tied to 0).
module mmio_wr_queue
  import mmio_q_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH_DEF,
  parameter int DEPTH = Q_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [Q_STATUS_W-1:0]    status,
  output logic [31:0]              push_cnt,
  output logic [31:0]              pop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          pop_udf;
  logic          push_ok;
  logic          push_ovf;

  // Flush wins over everything issued in the same cycle.
  assign pop_ok   = rd_en & ~flush & ~empty;
  assign pop_udf  = rd_en & ~flush & empty;
  assign push_ok  = wr_en & ~flush & (~full | pop_ok);
  assign push_ovf = wr_en & ~flush & full & ~pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  mmio_wr_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (pop_ok),
    .rzero (pop_udf),
    .raddr (rptr),
    .rdata (rd_data)
  );

  // DEPTH is a power of two, so natural pointer overflow is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= pop_ok | pop_udf;
      // A new error in the same cycle as clr_err keeps its flag set.
      overflow  <= push_ovf | (overflow & ~clr_err);
      underflow <= pop_udf  | (underflow & ~clr_err);
    end
  end

  always_comb begin
    status                     = '0;
    status[CW-1:0]             = count;
    status[CW + ST_EMPTY_REL]  = empty;
    status[CW + ST_FULL_REL]   = full;
    status[CW + ST_UNDER_REL]  = underflow;
    status[CW + ST_OVER_REL]   = overflow;
  end

`ifdef MMIO_WR_QUEUE_STATS_EN
  // Counters see only accepted operations; flush suppresses push_ok/pop_ok and leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (push_ok) push_cnt <= push_cnt + 32'd1;
      if (pop_ok)  pop_cnt  <= pop_cnt + 32'd1;
    end
  end
`else
  assign push_cnt = '0;
  assign pop_cnt  = '0;
`endif

endmodule
